// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and slot types for the pipeline stage register
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    typedef logic [1:0] occ_t;

    // Control part of a slot; the channel data travels alongside because its width is per-instance.
    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
    } slot_hdr_t;

    function automatic occ_t occ_count(input logic a, input logic b);
        return occ_t'({1'b0, a}) + occ_t'({1'b0, b});
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one pipeline storage entry with load, clear (flush) and drop controls
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int          DATA_W   = 128,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic              drop_i,
    input  logic [31:0]       instr_i,
    input  logic [31:0]       pc_i,
    input  logic [DATA_W-1:0] data_i,
    output slot_hdr_t         hdr_o,
    output logic [DATA_W-1:0] data_o
);

    slot_hdr_t         hdr_q, hdr_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Clear keeps the pc so a flushed stage still reports where it was.
    always_comb begin
        hdr_d  = hdr_q;
        data_d = data_q;
        if (clear_i) begin
            hdr_d.valid = 1'b0;
            hdr_d.instr = NOP_INSTR;
            data_d      = '0;
        end else if (load_i) begin
            hdr_d.valid = 1'b1;
            hdr_d.instr = instr_i;
            hdr_d.pc    = pc_i;
            data_d      = data_i;
        end else if (drop_i) begin
            hdr_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hdr_q.valid <= 1'b0;
            hdr_q.instr <= NOP_INSTR;
            hdr_q.pc    <= RESET_PC;
            data_q      <= '0;
        end else begin
            hdr_q  <= hdr_d;
            data_q <= data_d;
        end
    end

    assign hdr_o  = hdr_q;
    assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - handshaked inter-stage register with flush; PIPE_SKID_EN adds a skid slot
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int          NCH      = 4,
    parameter int          DW       = 32,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_pc,
    input  logic [NCH*DW-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic [NCH*DW-1:0] out_data,
    output occ_t              occupancy
);

    localparam int DATA_W = NCH * DW;

    slot_hdr_t         main_hdr;
    logic [DATA_W-1:0] main_data;
    logic              main_load, main_drop;
    logic [31:0]       main_instr_d, main_pc_d;
    logic [DATA_W-1:0] main_data_d;
    logic              in_fire, out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = main_hdr.valid && out_ready;

`ifdef PIPE_SKID_EN
    slot_hdr_t         skid_hdr;
    logic [DATA_W-1:0] skid_data;
    logic              skid_load, skid_drop;

    // Ready comes straight from a flop so out_ready never reaches upstream combinationally.
    assign in_ready = !skid_hdr.valid;

    always_comb begin
        main_load = 1'b0;
        main_drop = 1'b0;
        skid_load = 1'b0;
        skid_drop = 1'b0;
        if (!main_hdr.valid) begin
            main_load = in_fire;
        end else if (out_fire) begin
            if (skid_hdr.valid) begin
                main_load = 1'b1;
                skid_drop = 1'b1;
            end else if (in_fire) begin
                main_load = 1'b1;
            end else begin
                main_drop = 1'b1;
            end
        end else if (in_fire) begin
            skid_load = 1'b1;
        end
    end

    assign main_instr_d = skid_hdr.valid ? skid_hdr.instr : in_instr;
    assign main_pc_d    = skid_hdr.valid ? skid_hdr.pc    : in_pc;
    assign main_data_d  = skid_hdr.valid ? skid_data      : in_data;

    pipe_slot #(.DATA_W(DATA_W), .RESET_PC(RESET_PC)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skid_load),
        .clear_i (flush),
        .drop_i  (skid_drop),
        .instr_i (in_instr),
        .pc_i    (in_pc),
        .data_i  (in_data),
        .hdr_o   (skid_hdr),
        .data_o  (skid_data)
    );

    assign occupancy = occ_count(main_hdr.valid, skid_hdr.valid);
`else
    assign in_ready     = !main_hdr.valid || out_ready;
    assign main_load    = in_fire;
    assign main_drop    = out_fire && !in_fire;
    assign main_instr_d = in_instr;
    assign main_pc_d    = in_pc;
    assign main_data_d  = in_data;
    assign occupancy    = occ_count(main_hdr.valid, 1'b0);
`endif

    pipe_slot #(.DATA_W(DATA_W), .RESET_PC(RESET_PC)) u_main (
        .clk     (clk),
        .reset   (reset),
        .load_i  (main_load),
        .clear_i (flush),
        .drop_i  (main_drop),
        .instr_i (main_instr_d),
        .pc_i    (main_pc_d),
        .data_i  (main_data_d),
        .hdr_o   (main_hdr),
        .data_o  (main_data)
    );

    assign out_valid = main_hdr.valid;
    assign out_instr = main_hdr.valid ? main_hdr.instr : NOP_INSTR;
    assign out_pc    = main_hdr.pc;
    assign out_data  = main_hdr.valid ? main_data : '0;

endmodule
